// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM encoding and requester-id type for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-command signals of the arbiter bundled in one interface.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              r0_valid;
  logic              r1_valid;
  logic              r0_ready;
  logic              r1_ready;
  logic              r0_we;
  logic              r1_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [DATA_W-1:0] r1_wdata;
  logic              r0_rsp_valid;
  logic              r1_rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  // master: requesters plus memory (the environment); slave: the arbiter itself
  modport master (
    output r0_valid, r1_valid, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_data,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );

  modport slave (
    input  r0_valid, r1_valid, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rsp_data,
    output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin grant select: a lone valid requester wins, otherwise rr_ptr decides.
module mem_arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_rr_ptr,
  output logic       o_grant_valid,
  output req_id_t    o_grant_id
);

  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = i_rr_ptr;
    if (i_valid == 2'b01) begin
      o_grant_id = 1'b0;
    end else if (i_valid == 2'b10) begin
      o_grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter with bounded bursts and round-robin fairness.
// Optional MEM_ARB_STATS_EN adds saturating grant/conflict counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_grant0,
  output logic [15:0] stat_grant1,
  output logic [15:0] stat_conflict
`endif
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  req_id_t     r_owner;
  req_id_t     w_owner_nxt;
  req_id_t     r_rr_ptr;
  req_id_t     w_rr_ptr_nxt;
  req_id_t     r_tag;
  logic [3:0]  r_count;
  logic [3:0]  w_count_nxt;
  logic [3:0]  w_new_count;
  logic        r_rd_pending;

  logic [1:0]  w_valid;
  logic        w_own_valid;
  logic        w_pick_valid;
  req_id_t     w_pick_id;
  req_id_t     w_grant_id;
  logic        w_accept;
  logic        w_sel_we;

  assign w_valid     = {bus.r1_valid, bus.r0_valid};
  assign w_own_valid = r_owner ? bus.r1_valid : bus.r0_valid;

  // While a burst owner drops valid its bit is 0, so the picker hands the slot to the other side.
  mem_arb_rr_pick u_pick (
    .i_valid       (w_valid),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_pick_valid),
    .o_grant_id    (w_pick_id)
  );

  always_comb begin
    w_grant_id   = w_pick_id;
    w_accept     = w_pick_valid & rst;
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_count_nxt  = r_count;
    w_rr_ptr_nxt = r_rr_ptr;
    w_new_count  = 4'd1;

    if (r_state == ST_BURST && w_own_valid) begin
      w_grant_id = r_owner;
    end

    if (r_state == ST_BURST && !w_own_valid) begin
      w_state_nxt  = ST_IDLE;
      w_count_nxt  = 4'd0;
      w_rr_ptr_nxt = other_req(r_owner);
    end

    if (w_accept) begin
      if (r_state == ST_BURST && w_grant_id == r_owner) begin
        w_new_count = r_count + 4'd1;
      end
      w_owner_nxt = w_grant_id;
      if (w_new_count == MAX_CNT) begin
        w_state_nxt  = ST_IDLE;
        w_count_nxt  = 4'd0;
        w_rr_ptr_nxt = other_req(w_grant_id);
      end else begin
        w_state_nxt  = ST_BURST;
        w_count_nxt  = w_new_count;
      end
    end
  end

  assign w_sel_we      = w_grant_id ? bus.r1_we : bus.r0_we;
  assign bus.r0_ready  = w_accept && (w_grant_id == 1'b0);
  assign bus.r1_ready  = w_accept && (w_grant_id == 1'b1);
  assign bus.mem_wr_en = w_accept && w_sel_we;
  assign bus.mem_rd_en = w_accept && !w_sel_we;
  assign bus.mem_addr  = w_grant_id ? bus.r1_addr : bus.r0_addr;
  assign bus.mem_wdata = w_grant_id ? bus.r1_wdata : bus.r0_wdata;

  // Pending flag masks any memory return that belongs to a read issued before a reset.
  assign bus.r0_rsp_valid = bus.mem_rvalid && r_rd_pending && (r_tag == 1'b0);
  assign bus.r1_rsp_valid = bus.mem_rvalid && r_rd_pending && (r_tag == 1'b1);
  assign bus.rsp_data     = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_count      <= 4'd0;
      r_tag        <= 1'b0;
      r_rd_pending <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_count      <= w_count_nxt;
      r_rd_pending <= w_accept && !w_sel_we;
      if (w_accept && !w_sel_we) begin
        r_tag <= w_grant_id;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stat_grant0;
  logic [15:0] r_stat_grant1;
  logic [15:0] r_stat_conflict;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_grant0   <= 16'd0;
      r_stat_grant1   <= 16'd0;
      r_stat_conflict <= 16'd0;
    end else begin
      if (bus.r0_ready && r_stat_grant0 != 16'hFFFF) begin
        r_stat_grant0 <= r_stat_grant0 + 16'd1;
      end
      if (bus.r1_ready && r_stat_grant1 != 16'hFFFF) begin
        r_stat_grant1 <= r_stat_grant1 + 16'd1;
      end
      if ((&w_valid) && r_stat_conflict != 16'hFFFF) begin
        r_stat_conflict <= r_stat_conflict + 16'd1;
      end
    end
  end

  assign stat_grant0   = r_stat_grant0;
  assign stat_grant1   = r_stat_grant1;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a behavioural arbitration/memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   g = -1;

  logic [31:0] mem    [0:16383];
  logic [31:0] refMem [0:16383];

  logic        rv    [2];
  logic        rwe   [2];
  logic [13:0] raddr [2];
  logic [31:0] rdat  [2];

  bit          mBusy;
  int          mOwner;
  int          mBeats;
  int          mFavour;
  bit          expRsp [2];
  logic [31:0] expRspData;
  int          mStat  [3];

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] statGrant0;
  logic [15:0] statGrant1;
  logic [15:0] statConflict;
`endif

  mem_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_grant0   (statGrant0),
    .stat_grant1   (statGrant1),
    .stat_conflict (statConflict)
`endif
  );

  // Memory model: ignores reset so a read issued just before reset still returns data.
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rvalid <= bus.mem_rd_en;
    bus.mem_rdata  <= bus.mem_rd_en ? mem[bus.mem_addr] : 32'h0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic we, input logic [13:0] a, input logic [31:0] d);
    rv[i] = v; rwe[i] = we; raddr[i] = a; rdat[i] = d;
  endtask

  task automatic clearReq();
    setReq(0, 1'b0, 1'b0, 14'h0, 32'h0);
    setReq(1, 1'b0, 1'b0, 14'h0, 32'h0);
  endtask

  task automatic applyStimulus();
    bus.r0_valid = rv[0];  bus.r1_valid = rv[1];
    bus.r0_we    = rwe[0]; bus.r1_we    = rwe[1];
    bus.r0_addr  = raddr[0]; bus.r1_addr = raddr[1];
    bus.r0_wdata = rdat[0];  bus.r1_wdata = rdat[1];
  endtask

  task automatic modelReset();
    mBusy = 0; mOwner = 0; mBeats = 0; mFavour = 0;
    expRsp[0] = 0; expRsp[1] = 0; expRspData = 32'h0;
    mStat[0] = 0; mStat[1] = 0; mStat[2] = 0;
  endtask

  // Who should win this cycle: the burst owner while it keeps asking, else round-robin.
  function automatic int modelGrant();
    if (mBusy && rv[mOwner]) return mOwner;
    if (rv[0] && rv[1]) return mFavour;
    if (rv[0]) return 0;
    if (rv[1]) return 1;
    return -1;
  endfunction

  task automatic modelUpdate(input int gr);
    expRsp[0] = 0; expRsp[1] = 0;
    if (rv[0] && rv[1] && mStat[2] < 65535) mStat[2]++;
    if (mBusy && !rv[mOwner]) begin
      mBusy = 0;
      mFavour = 1 - mOwner;
    end
    if (gr >= 0) begin
      if (mBusy && gr == mOwner) mBeats++;
      else begin mOwner = gr; mBeats = 1; end
      if (mBeats == MAX_BURST) begin mBusy = 0; mFavour = 1 - gr; end
      else mBusy = 1;
      if (rwe[gr]) refMem[raddr[gr]] = rdat[gr];
      else begin expRsp[gr] = 1; expRspData = refMem[raddr[gr]]; end
      if (mStat[gr] < 65535) mStat[gr]++;
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic doCycle(output int gr);
    logic wantWr, wantRd;
    #1;
    gr = modelGrant();
    wantWr = 1'b0; wantRd = 1'b0;
    if (gr >= 0) begin wantWr = rwe[gr]; wantRd = !rwe[gr]; end
    checkOutput("r0_ready", bus.r0_ready, gr == 0);
    checkOutput("r1_ready", bus.r1_ready, gr == 1);
    checkOutput("mem_wr_en", bus.mem_wr_en, wantWr);
    checkOutput("mem_rd_en", bus.mem_rd_en, wantRd);
    if (gr >= 0) begin
      checkOutput("mem_addr", bus.mem_addr, raddr[gr]);
      if (rwe[gr]) checkOutput("mem_wdata", bus.mem_wdata, rdat[gr]);
    end
    checkOutput("r0_rsp_valid", bus.r0_rsp_valid, expRsp[0]);
    checkOutput("r1_rsp_valid", bus.r1_rsp_valid, expRsp[1]);
    if (expRsp[0] || expRsp[1]) checkOutput("rsp_data", bus.rsp_data, expRspData);
`ifdef MEM_ARB_STATS_EN
    checkOutput("stat_grant0", statGrant0, mStat[0]);
    checkOutput("stat_grant1", statGrant1, mStat[1]);
    checkOutput("stat_conflict", statConflict, mStat[2]);
`endif
    @(posedge clk);
    modelUpdate(gr);
    @(negedge clk);
  endtask

  task automatic applyReset(input int n);
    rst = 1'b0;
    clearReq();
    applyStimulus();
    modelReset();
    repeat (n) begin
      #1;
      checkOutput("rst_r0_ready", bus.r0_ready, 1'b0);
      checkOutput("rst_r1_ready", bus.r1_ready, 1'b0);
      checkOutput("rst_wr_en", bus.mem_wr_en, 1'b0);
      checkOutput("rst_rd_en", bus.mem_rd_en, 1'b0);
      checkOutput("rst_r0_rsp", bus.r0_rsp_valid, 1'b0);
      checkOutput("rst_r1_rsp", bus.r1_rsp_valid, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B1 + 32'h5;
      refMem[i] = mem[i];
    end
    mem[16383] = 32'hDEADBEEF; refMem[16383] = 32'hDEADBEEF;
    mem[0]     = 32'h12345678; refMem[0]     = 32'h12345678;
    clearReq();
    applyStimulus();
    modelReset();
    @(negedge clk);
    applyReset(3);

    // Simultaneous writes to one address: r0 first, r1 second, r1's data survives.
    setReq(0, 1'b1, 1'b1, 14'h0010, 32'hAAAA0000);
    setReq(1, 1'b1, 1'b1, 14'h0010, 32'hBBBB1111);
    applyStimulus(); doCycle(g);
    checkOutput("req034_first", g, 0);
    rv[0] = 1'b0;
    applyStimulus(); doCycle(g);
    checkOutput("req034_second", g, 1);
    clearReq(); applyStimulus(); doCycle(g);
    checkOutput("req034_mem", mem[16], 32'hBBBB1111);

    // Both requesters always valid: bursts of MAX_BURST alternate with no gaps.
    applyReset(1);
    setReq(0, 1'b1, 1'b1, 14'h0100, $urandom);
    setReq(1, 1'b1, 1'b1, 14'h0200, $urandom);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(); doCycle(g);
      checkOutput($sformatf("req035_grant%0d", i), g, (i / MAX_BURST) % 2);
      if (g >= 0) begin raddr[g] = raddr[g] + 14'd1; rdat[g] = $urandom; end
    end
    clearReq(); applyStimulus(); doCycle(g);

    // Back-to-back reads from alternating requesters, including the top address.
    applyReset(1);
    setReq(0, 1'b1, 1'b0, 14'h3FFF, 32'h0);
    applyStimulus(); doCycle(g);
    checkOutput("req036_r0_rsp", bus.r0_rsp_valid, 1'b1);
    checkOutput("req036_r0_data", bus.rsp_data, 32'hDEADBEEF);
    setReq(0, 1'b0, 1'b0, 14'h0, 32'h0);
    setReq(1, 1'b1, 1'b0, 14'h0000, 32'h0);
    applyStimulus(); doCycle(g);
    checkOutput("req036_r1_grant", g, 1);
    checkOutput("req036_r1_rsp", bus.r1_rsp_valid, 1'b1);
    checkOutput("req036_r0_quiet", bus.r0_rsp_valid, 1'b0);
    checkOutput("req036_r1_data", bus.rsp_data, 32'h12345678);
    clearReq(); applyStimulus(); doCycle(g);

    // Owner drops valid after two beats: r1 takes over immediately and gets a full burst.
    applyReset(1);
    setReq(0, 1'b1, 1'b1, 14'h0300, $urandom);
    setReq(1, 1'b1, 1'b1, 14'h0400, $urandom);
    for (int i = 0; i < 7; i++) begin
      int expG;
      expG = (i < 2 || i == 6) ? 0 : 1;
      rv[0] = (i != 2);
      applyStimulus(); doCycle(g);
      checkOutput($sformatf("req037_grant%0d", i), g, expG);
      if (g >= 0) begin raddr[g] = raddr[g] + 14'd1; rdat[g] = $urandom; end
    end
    clearReq(); applyStimulus(); doCycle(g);

    // Reset right after a read is accepted: no response, and r0 favoured again.
    applyReset(1);
    setReq(0, 1'b1, 1'b1, 14'h0500, 32'h01020304);
    applyStimulus(); doCycle(g);
    setReq(0, 1'b0, 1'b0, 14'h0, 32'h0);
    setReq(1, 1'b1, 1'b0, 14'h0010, 32'h0);
    applyStimulus(); doCycle(g);
    checkOutput("req038_read_grant", g, 1);
    applyReset(2);
    setReq(0, 1'b1, 1'b1, 14'h0600, 32'h11111111);
    setReq(1, 1'b1, 1'b1, 14'h0700, 32'h22222222);
    applyStimulus(); doCycle(g);
    checkOutput("req038_rr", g, 0);
    clearReq(); applyStimulus(); doCycle(g);

`ifdef MEM_ARB_STATS_EN
    applyReset(1);
    setReq(0, 1'b1, 1'b1, 14'h0800, $urandom);
    setReq(1, 1'b1, 1'b1, 14'h0900, $urandom);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(); doCycle(g);
      if (g >= 0) begin raddr[g] = raddr[g] + 14'd1; rdat[g] = $urandom; end
    end
    checkOutput("req039_conflict", statConflict, 32'd10);
    checkOutput("req039_sum", 32'(statGrant0) + 32'(statGrant1), 32'd10);
    clearReq(); applyStimulus(); doCycle(g);
`endif

    // Random traffic; a requester holds its beat until it is accepted.
    clearReq();
    g = -1;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        applyReset(2);
        g = -1;
      end
      for (int i = 0; i < 2; i++) begin
        if (!(rv[i] && g != i)) begin
          rv[i]    = ($urandom_range(0, 9) < 7);
          rwe[i]   = 1'($urandom_range(0, 1));
          raddr[i] = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
          rdat[i]  = $urandom;
        end
      end
      applyStimulus(); doCycle(g);
    end
    clearReq(); applyStimulus(); doCycle(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
